adder_slice_sequencer: RTL and testbench

//  Multi-cycle controller computing a WIDTH-bit add on one shared SLICE-bit combinational adder.
//  - Walks the operands LSB slice first over WIDTH/SLICE cycles, chaining carry through a register.
//  - Drives the external adder through the add_* ports.
//  - Returns the result on a valid/ready response channel.
//  - Lets the 64-bit LEGv8 datapath reuse the existing 32-bit adder hardware.

---
 rtl/adder_slice_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_adder_slice_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_slice_sequencer.sv
// adder_slice_sequencer
//   Computes a WIDTH-bit add (or subtract) by walking one shared SLICE-bit
//   combinational adder across WIDTH/SLICE consecutive cycles, LSB slice
//   first. The carry between slices is held in a register. The result is
//   returned on a valid/ready response channel.
//
//   Optional feature macro: SUB_EN
//     defined   : op_sub selects A-B (B slices inverted, initial carry 1;
//                 c_out=1 means no borrow)
//     undefined : op_sub is ignored and the block always adds.
//
//   WIDTH must be an integer multiple of SLICE. WIDTH == SLICE is legal and
//   gives a single-cycle RUN phase.

module adder_slice_sequencer #(
    parameter int WIDTH = 64,
    parameter int SLICE = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             op_sub,
    output logic [SLICE-1:0] add_a,
    output logic [SLICE-1:0] add_b,
    output logic             add_cin,
    input  logic [SLICE-1:0] add_sum,
    input  logic             add_cout,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int N     = WIDTH / SLICE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    // One-slice-wide mask in the low bits of a WIDTH vector.
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE{1'b1}});

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q,      state_d;
    logic [IDX_W-1:0]   idx_q,        idx_d;
    logic               carry_q,      carry_d;
    logic [WIDTH-1:0]   a_q,          a_d;
    // b_q holds B exactly as fed to the adder (already inverted for subtract).
    logic [WIDTH-1:0]   b_q,          b_d;
    logic [WIDTH-1:0]   sum_q,        sum_d;
    logic               c_out_q,      c_out_d;
    logic               ovf_q,        ovf_d;
    logic               resp_valid_q, resp_valid_d;
    logic               req_ready_q,  req_ready_d;

    logic               sub_s;
    int                 base_s;

`ifdef SUB_EN
    assign sub_s = op_sub;
`else
    // Subtract support is not built; the port is kept for interface stability.
    logic unused_op_sub;
    assign unused_op_sub = op_sub;
    assign sub_s         = 1'b0;
`endif

    // Bit offset of the slice currently being processed.
    assign base_s = int'(idx_q) * SLICE;

    // Drive the shared adder only while running; keep its inputs quiet otherwise.
    always_comb begin
        add_a   = {SLICE{1'b0}};
        add_b   = {SLICE{1'b0}};
        add_cin = 1'b0;
        if (state_q == RUN) begin
            add_a   = SLICE'(a_q >> base_s);
            add_b   = SLICE'(b_q >> base_s);
            add_cin = carry_q;
        end else begin
            add_a   = {SLICE{1'b0}};
            add_b   = {SLICE{1'b0}};
            add_cin = 1'b0;
        end
    end

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        carry_d      = carry_q;
        a_d          = a_q;
        b_d          = b_q;
        sum_d        = sum_q;
        c_out_d      = c_out_q;
        ovf_d        = ovf_q;
        resp_valid_d = resp_valid_q;
        req_ready_d  = req_ready_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    a_d          = a_in;
                    b_d          = sub_s ? ~b_in : b_in;
                    carry_d      = sub_s;
                    idx_d        = IDX_W'(0);
                    sum_d        = WIDTH'(0);
                    c_out_d      = 1'b0;
                    ovf_d        = 1'b0;
                    req_ready_d  = 1'b0;
                    resp_valid_d = 1'b0;
                    state_d      = RUN;
                end else begin
                    req_ready_d  = 1'b1;
                    resp_valid_d = 1'b0;
                end
            end

            RUN: begin
                sum_d   = (sum_q & ~(SLICE_MASK << base_s))
                        | (WIDTH'(add_sum) << base_s);
                carry_d = add_cout;
                if (idx_q == IDX_W'(N - 1)) begin
                    c_out_d      = add_cout;
                    // Operand signs agree but the result sign differs.
                    ovf_d        = (a_q[WIDTH-1] == b_q[WIDTH-1])
                                && (add_sum[SLICE-1] != a_q[WIDTH-1]);
                    resp_valid_d = 1'b1;
                    state_d      = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            DONE: begin
                // The response cycle never doubles as an accept cycle.
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
                end else begin
                    resp_valid_d = 1'b1;
                    req_ready_d  = 1'b0;
                end
            end

            default: begin
                state_d      = IDLE;
                idx_d        = IDX_W'(0);
                carry_d      = 1'b0;
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= IDX_W'(0);
            carry_q      <= 1'b0;
            a_q          <= WIDTH'(0);
            b_q          <= WIDTH'(0);
            sum_q        <= WIDTH'(0);
            c_out_q      <= 1'b0;
            ovf_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            carry_q      <= carry_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sum_q        <= sum_d;
            c_out_q      <= c_out_d;
            ovf_q        <= ovf_d;
            resp_valid_q <= resp_valid_d;
            req_ready_q  <= req_ready_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign sum        = sum_q;
    assign c_out      = c_out_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_adder_slice_sequencer.sv
// Self-checking bench for adder_slice_sequencer (WIDTH=64, SLICE=32).
// The shared 32-bit adder is modelled here; expected results are hand-computed.

module tb_adder_slice_sequencer;

    localparam int WIDTH = 64;
    localparam int SLICE = 32;
    localparam int N     = WIDTH / SLICE;
    localparam int NV    = 8;

    logic             clk;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             op_sub;
    logic [SLICE-1:0] add_a;
    logic [SLICE-1:0] add_b;
    logic             add_cin;
    logic [SLICE-1:0] add_sum;
    logic             add_cout;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic [63:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs [NV];
    int   n_checks;
    int   n_fail;

    adder_slice_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .a_in       (a_in),
        .b_in       (b_in),
        .op_sub     (op_sub),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_cin    (add_cin),
        .add_sum    (add_sum),
        .add_cout   (add_cout),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .sum        (sum),
        .c_out      (c_out),
        .ovf        (ovf)
    );

    // Shared combinational slice adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Counts clock edges from acceptance until resp_valid, bounded.
    task automatic wait_resp(output int cycles);
        cycles = 0;
        while (!resp_valid && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    // Full transaction; called and returns at a negedge with the DUT in IDLE.
    task automatic run_vec(input vec_t v);
        int   cycles;
        logic exp_cin;
`ifdef SUB_EN
        exp_cin = v.sub;
`else
        exp_cin = 1'b0;
`endif
        check("req_ready_idle", 64'(req_ready), 64'd1);
        check("add_a_idle", 64'(add_a), 64'd0);
        req_valid = 1'b1;
        a_in      = v.a;
        b_in      = v.b;
        op_sub    = v.sub;
        @(negedge clk);
        req_valid = 1'b0;
        check("req_ready_run", 64'(req_ready), 64'd0);
        check("add_a_slice0", 64'(add_a), 64'(v.a[31:0]));
        check("add_cin_slice0", 64'(add_cin), 64'(exp_cin));
        wait_resp(cycles);
        check("latency", 64'(cycles), 64'(N));
        check("sum", sum, v.s);
        check("c_out", 64'(c_out), 64'(v.co));
        check("ovf", 64'(ovf), 64'(v.ov));
        check("add_a_done", 64'(add_a), 64'd0);
        check("req_ready_done", 64'(req_ready), 64'd0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("resp_valid_after", 64'(resp_valid), 64'd0);
        check("req_ready_after", 64'(req_ready), 64'd1);
    endtask

    initial begin
        int   cycles;
        vec_t first_v;
        vec_t second_v;

        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
        vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
        vecs[4] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 64'h2222_2222_2222_2211, 1'b0, 1'b0};
        vecs[5] = '{64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0};
`ifdef SUB_EN
        vecs[6] = '{64'h0000_0001_0000_0000, 64'h1, 1'b1, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0};
        vecs[7] = '{64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
`else
        vecs[6] = '{64'h0000_0001_0000_0000, 64'h1, 1'b1, 64'h0000_0001_0000_0001, 1'b0, 1'b0};
        vecs[7] = '{64'h0, 64'h1, 1'b1, 64'h1, 1'b0, 1'b0};
`endif

        reset      = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        a_in       = 64'h0;
        b_in       = 64'h0;
        op_sub     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_sum", sum, 64'h0);
        check("rst_c_out", 64'(c_out), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_add_b", 64'(add_b), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i]);
        end

        // Back-to-back with backpressure: req_valid stays high throughout.
        first_v    = vecs[4];
        second_v   = vecs[0];
        req_valid  = 1'b1;
        a_in       = first_v.a;
        b_in       = first_v.b;
        op_sub     = 1'b0;
        @(negedge clk);
        wait_resp(cycles);
        check("b2b_latency", 64'(cycles), 64'(N));
        a_in = second_v.a;
        b_in = second_v.b;
        for (int k = 0; k < 5; k++) begin
            check("bp_resp_valid", 64'(resp_valid), 64'd1);
            check("bp_sum", sum, first_v.s);
            check("bp_req_ready", 64'(req_ready), 64'd0);
            check("bp_add_a", 64'(add_a), 64'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("b2b_idle_resp_valid", 64'(resp_valid), 64'd0);
        check("b2b_idle_req_ready", 64'(req_ready), 64'd1);
        check("b2b_idle_add_a", 64'(add_a), 64'd0);
        check("b2b_idle_add_cin", 64'(add_cin), 64'd0);
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b_second_accepted", 64'(req_ready), 64'd0);
        check("b2b_second_slice0", 64'(add_a), 64'(second_v.a[31:0]));
        wait_resp(cycles);
        check("b2b_second_latency", 64'(cycles), 64'(N));
        check("b2b_second_sum", sum, second_v.s);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;

        // Reset after slice 0 has completed; partial result must be discarded.
        req_valid = 1'b1;
        a_in      = 64'h1111_1111_2222_2222;
        b_in      = 64'h0000_0000_3333_3333;
        op_sub    = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_sum", sum, 64'h0);
        check("mid_rst_req_ready", 64'(req_ready), 64'd1);
        check("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
        check("mid_rst_add_a", 64'(add_a), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_vec(vecs[2]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
